// File: rtl/alu_cu_pkg.sv
// Shared types for the ALU control unit with the RV32M multiply/divide sequencer.
// Holds the op-class, ALU-op, M-op and sequencer-state enums plus the base
// funct3 -> ALU-op mapping used by both R-type and I-type decode.
package alu_cu_pkg;

  // Op class from the main decoder; 5..7 are reserved.
  typedef enum logic [2:0] {
    ClsAdd    = 3'd0,
    ClsBranch = 3'd1,
    ClsRtype  = 3'd2,
    ClsItype  = 3'd3,
    ClsLui    = 3'd4
  } alu_cls_e;

  typedef enum logic [3:0] {
    OpAdd   = 4'b0000,
    OpSub   = 4'b0001,
    OpSll   = 4'b0010,
    OpSlt   = 4'b0011,
    OpSltu  = 4'b0100,
    OpXor   = 4'b0101,
    OpSrl   = 4'b0110,
    OpSra   = 4'b0111,
    OpOr    = 4'b1000,
    OpAnd   = 4'b1001,
    OpPassB = 4'b1010,
    OpMd    = 4'b1111
  } alu_op_e;

  typedef enum logic [2:0] {
    MdMul    = 3'b000,
    MdMulh   = 3'b001,
    MdMulhsu = 3'b010,
    MdMulhu  = 3'b011,
    MdDiv    = 3'b100,
    MdDivu   = 3'b101,
    MdRem    = 3'b110,
    MdRemu   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } md_state_e;

  // funct3 table; alt (INST[30]) only matters for 000 (SUB) and 101 (SRA).
  function automatic alu_op_e base_op(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    unique case (funct3)
      3'b000:  op = alt ? OpSub : OpAdd;
      3'b001:  op = OpSll;
      3'b010:  op = OpSlt;
      3'b011:  op = OpSltu;
      3'b100:  op = OpXor;
      3'b101:  op = alt ? OpSra : OpSrl;
      3'b110:  op = OpOr;
      default: op = OpAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/md_iter.sv
// Iterative RV32M datapath: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with the sign fixup folded into the final-cycle result.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             load operands/funct3, counter <= XLEN
//   step              perform one iteration, counter decrements
//   funct3, a, b      M-op select and operands (sampled on start)
//   result            value after the current step (valid when last)
//   last              counter == 1: this step is the final one
module md_iter
  import alu_cu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            step,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            last
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  logic [CntW-1:0] cnt_q;
  // mul: {hi,lo} is the product shift register, aux = |a|
  // div: hi = partial remainder, lo = dividend/quotient, aux = |b|
  logic [XLEN-1:0] hi_q, lo_q, aux_q;
  logic [2:0]      f3_q;
  logic            neg_q;

  logic            is_div, sgn_a, sgn_b, sa, sb, neg_start;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    is_div = funct3[2];
    sgn_a  = is_div ? ~funct3[0] : (funct3 != MdMulhu);
    sgn_b  = is_div ? ~funct3[0] : ~funct3[1];
    sa     = sgn_a & a[XLEN-1];
    sb     = sgn_b & b[XLEN-1];
    abs_a  = sa ? -a : a;
    abs_b  = sb ? -b : b;
    if (!is_div) begin
      neg_start = sa ^ sb;
    end else if (funct3[1]) begin
      neg_start = sa;
    end else begin
      // Quotient of x/0 stays all-ones regardless of the dividend sign.
      neg_start = (sa ^ sb) & (b != '0);
    end
  end

  logic [XLEN:0]     mul_sum, div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   hi_d, lo_d, quo_rem;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, aux_q} : '0);
    div_sh  = {hi_q, lo_q[XLEN-1]};
    div_ge  = div_sh >= {1'b0, aux_q};
    if (f3_q[2]) begin
      // Remainder < divisor, so the low XLEN bits of the difference are exact.
      hi_d = div_ge ? (div_sh[XLEN-1:0] - aux_q) : div_sh[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], div_ge};
    end else begin
      hi_d = mul_sum[XLEN:1];
      lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod    = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    quo_rem = f3_q[1] ? hi_d : lo_d;
    if (neg_q) quo_rem = -quo_rem;
    if (f3_q[2]) begin
      result = quo_rem;
    end else if (f3_q == MdMul) begin
      result = prod[XLEN-1:0];
    end else begin
      result = prod[2*XLEN-1:XLEN];
    end
    last = (cnt_q == CntW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      aux_q <= '0;
      f3_q  <= '0;
      neg_q <= 1'b0;
    end else if (start) begin
      cnt_q <= CntW'(XLEN);
      hi_q  <= '0;
      lo_q  <= is_div ? abs_a : abs_b;
      aux_q <= is_div ? abs_b : abs_a;
      f3_q  <= funct3;
      neg_q <= neg_start;
    end else if (step) begin
      cnt_q <= cnt_q - CntW'(1);
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: rtl/alu_cu_md.sv
// ALU control unit: combinational decode of op class + instruction fields into
// an ALU op select, plus a stall/done sequencer for RV32M multiply/divide.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ALU_INST, INST    op class and {INST[25], INST[30], funct3}
//   valid, flush      instruction valid in execute; abort in-flight M op
//   op_a, op_b        rs1 / rs2 values
//   ALUops, illegal   decoded ALU op and unsupported-encoding flag
//   stall             hold the pipeline while an M op runs
//   md_done           one-cycle pulse, md_result valid
//   md_result         last completed M-op result
module alu_cu_md
  import alu_cu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          EN_M     = 1'b1,
  parameter bit          SHORTCUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      ALU_INST,
  input  logic [4:0]      INST,
  input  logic            valid,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      ALUops,
  output logic            stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic            illegal
);

  alu_op_e dec_op;
  logic    dec_ill;

  always_comb begin
    dec_op  = OpAdd;
    dec_ill = 1'b0;
    case (ALU_INST)
      ClsAdd: dec_op = OpAdd;
      ClsBranch: begin
        unique case (INST[2:1])
          2'b00: dec_op = OpSub;
          2'b01: begin
            dec_op  = OpSub;
            dec_ill = 1'b1;
          end
          2'b10: dec_op = OpSlt;
          default: dec_op = OpSltu;
        endcase
      end
      ClsRtype: begin
        if (INST[4]) begin
          if (EN_M) dec_op = OpMd;
          else      dec_ill = 1'b1;
        end else begin
          dec_op  = base_op(INST[2:0], INST[3]);
          dec_ill = INST[3] && (INST[2:0] != 3'b000) && (INST[2:0] != 3'b101);
        end
      end
      ClsItype: begin
        // Only SRAI uses INST[30]; SLLI with it set is not a valid encoding.
        dec_op  = base_op(INST[2:0], INST[3] && (INST[2:0] == 3'b101));
        dec_ill = INST[3] && (INST[2:0] == 3'b001);
      end
      ClsLui:  dec_op = OpPassB;
      default: dec_ill = 1'b1;
    endcase
  end

  assign ALUops  = dec_op;
  assign illegal = dec_ill;

  if (EN_M) begin : g_md
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_q;
    logic [XLEN-1:0] result_q, iter_result, short_result;
    logic            m_op, accept, bz, ovf, short_hit, start, step, last;

    always_comb begin
      m_op      = valid && (ALU_INST == ClsRtype) && INST[4] && !dec_ill;
      accept    = (state_q == StIdle) && m_op && !flush;
      bz        = (op_b == '0);
      ovf       = !INST[0] && (op_a == MinVal) && (op_b == '1);
      short_hit = SHORTCUT && INST[2] && (bz || ovf);
      // REM-class picks the remainder, DIV-class the quotient.
      short_result = INST[1] ? (bz ? op_a : '0) : (bz ? '1 : MinVal);
      start     = accept && !short_hit;
      step      = (state_q == StBusy) && !flush;
    end

    md_iter #(
      .XLEN(XLEN)
    ) u_md_iter (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .step  (step),
      .funct3(INST[2:0]),
      .a     (op_a),
      .b     (op_b),
      .result(iter_result),
      .last  (last)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= StIdle;
        result_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              if (short_hit) begin
                result_q <= short_result;
                state_q  <= StDone;
              end else begin
                state_q <= StBusy;
              end
            end
          end
          StBusy: begin
            if (flush) begin
              state_q <= StIdle;
            end else if (last) begin
              result_q <= iter_result;
              state_q  <= StDone;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    assign stall     = accept || (state_q == StBusy);
    assign md_done   = (state_q == StDone);
    assign md_result = result_q;
  end else begin : g_no_md
    assign stall     = 1'b0;
    assign md_done   = 1'b0;
    assign md_result = '0;
  end

endmodule

// File: tb/tb_alu_cu_md.sv
module tb_alu_cu_md;

  localparam logic [31:0] MinVal = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alu_inst;
  logic [4:0]  inst;
  logic        valid, flush;
  logic [31:0] op_a, op_b;

  logic [3:0]  alu_ops, ns_alu_ops, nom_alu_ops;
  logic        stall, md_done, illegal;
  logic        ns_stall, ns_md_done, ns_illegal;
  logic        nom_stall, nom_md_done, nom_illegal;
  logic [31:0] md_result, ns_md_result, nom_md_result;

  int n_checks = 0;
  int n_pass   = 0;
  int nom_busy = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  alu_cu_md #(.XLEN(32), .EN_M(1'b1), .SHORTCUT(1'b1)) dut (
    .clk(clk), .rst(rst), .ALU_INST(alu_inst), .INST(inst), .valid(valid), .flush(flush),
    .op_a(op_a), .op_b(op_b), .ALUops(alu_ops), .stall(stall), .md_done(md_done),
    .md_result(md_result), .illegal(illegal)
  );

  alu_cu_md #(.XLEN(32), .EN_M(1'b1), .SHORTCUT(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .ALU_INST(alu_inst), .INST(inst), .valid(valid), .flush(flush),
    .op_a(op_a), .op_b(op_b), .ALUops(ns_alu_ops), .stall(ns_stall), .md_done(ns_md_done),
    .md_result(ns_md_result), .illegal(ns_illegal)
  );

  alu_cu_md #(.XLEN(32), .EN_M(1'b0), .SHORTCUT(1'b1)) dut_nom (
    .clk(clk), .rst(rst), .ALU_INST(alu_inst), .INST(inst), .valid(valid), .flush(flush),
    .op_a(op_a), .op_b(op_b), .ALUops(nom_alu_ops), .stall(nom_stall), .md_done(nom_md_done),
    .md_result(nom_md_result), .illegal(nom_illegal)
  );

  always @(negedge clk) begin
    if (nom_stall !== 1'b0 || nom_md_done !== 1'b0) nom_busy++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Decode reference: returns {op_defined, illegal, op}.
  function automatic logic [5:0] ref_dec(input logic [2:0] cls, input logic [4:0] in,
                                         input bit en_m);
    logic [3:0] base [8];
    logic [2:0] f3;
    base = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
    f3 = in[2:0];
    case (cls)
      3'd0: return {2'b10, 4'h0};
      3'd1: begin
        if (f3[2]) return {2'b10, f3[1] ? 4'h4 : 4'h3};
        return {1'b1, f3[1], 4'h1};
      end
      3'd2: begin
        if (in[4]) return en_m ? {2'b10, 4'hF} : {2'b11, 4'h0};
        if (in[3]) begin
          if (f3 == 3'd0) return {2'b10, 4'h1};
          if (f3 == 3'd5) return {2'b10, 4'h7};
          return {2'b01, 4'h0};
        end
        return {2'b10, base[f3]};
      end
      3'd3: begin
        if (in[3] && f3 == 3'd5) return {2'b10, 4'h7};
        if (in[3] && f3 == 3'd1) return {2'b01, 4'h0};
        return {2'b10, base[f3]};
      end
      3'd4: return {2'b10, 4'hA};
      default: return {2'b11, 4'h0};
    endcase
  endfunction

  // RV32M reference computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MinVal && b == 32'hFFFF_FFFF) return MinVal;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MinVal && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic dec_check(input logic [2:0] cls, input logic [4:0] in, input string tag);
    logic [5:0] m, mn;
    alu_inst = cls;
    inst     = in;
    valid    = 1'b0;
    #1;
    m  = ref_dec(cls, in, 1'b1);
    mn = ref_dec(cls, in, 1'b0);
    check_eq({tag, "/ill"}, illegal, m[4]);
    if (m[5]) check_eq({tag, "/op"}, alu_ops, m[3:0]);
    check_eq({tag, "/nom_ill"}, nom_illegal, mn[4]);
    if (mn[5]) check_eq({tag, "/nom_op"}, nom_alu_ops, mn[3:0]);
  endtask

  task automatic md_run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] exp, got_res, ns_res;
    int lat, got_lat, ns_lat, dones, ns_dones, busy_st;
    exp = ref_md(f3, a, b);
    lat = (f3[2] && (b == 0 || (!f3[0] && a == MinVal && b == 32'hFFFF_FFFF))) ? 1 : 33;
    @(negedge clk);
    alu_inst = 3'd2; inst = {2'b10, f3}; op_a = a; op_b = b; valid = 1'b1;
    #1;
    check_eq({tag, "/stall_acc"}, stall, 1'b1);
    @(negedge clk);
    valid = 1'b0;
    got_lat = -1; ns_lat = -1; dones = 0; ns_dones = 0; busy_st = 0;
    got_res = '0; ns_res = '0;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (md_done) begin
        dones++;
        if (got_lat < 0) begin got_lat = c; got_res = md_result; end
      end else if (got_lat < 0 && stall) begin
        busy_st++;
      end
      if (ns_md_done) begin
        ns_dones++;
        if (ns_lat < 0) begin ns_lat = c; ns_res = ns_md_result; end
      end
      @(negedge clk);
    end
    check_eq({tag, "/res"}, got_res, exp);
    check_eq({tag, "/lat"}, got_lat, lat);
    check_eq({tag, "/ndone"}, dones, 1);
    check_eq({tag, "/stall_busy"}, busy_st, lat - 1);
    check_eq({tag, "/ns_res"}, ns_res, exp);
    check_eq({tag, "/ns_lat"}, ns_lat, 33);
    check_eq({tag, "/ns_ndone"}, ns_dones, 1);
    last_res = exp;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MinVal;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dn;
    rst = 1'b1; alu_inst = '0; inst = '0; valid = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    last_res = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst/stall", stall, 1'b0);
    check_eq("rst/done", md_done, 1'b0);
    check_eq("rst/result", md_result, 32'h0);

    // Decode: directed points, then random class/field combinations.
    dec_check(3'd2, 5'b01000, "dec_sub");
    dec_check(3'd3, 5'b01000, "dec_addi");
    dec_check(3'd3, 5'b01101, "dec_srai");
    dec_check(3'd1, 5'b00110, "dec_bltu");
    dec_check(3'd1, 5'b00010, "dec_br01x");
    dec_check(3'd6, 5'b00000, "dec_rsvd");
    dec_check(3'd2, 5'b10000, "dec_mul");
    dec_check(3'd3, 5'b01001, "dec_slli_bad");
    for (int i = 0; i < 120; i++) begin
      dec_check(3'($urandom_range(0, 7)), 5'($urandom), "dec_rand");
    end

    md_run(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
    md_run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    md_run(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu");
    md_run(3'd1, MinVal, MinVal, "mulh");
    md_run(3'd4, 32'hFFFF_FFF9, 32'd2, "div");
    md_run(3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
    md_run(3'd4, 32'd5, 32'd0, "div0");
    md_run(3'd4, 32'hFFFF_FFF9, 32'd0, "div0_neg");
    md_run(3'd6, 32'd5, 32'd0, "rem0");
    md_run(3'd5, 32'd5, 32'd0, "divu0");
    md_run(3'd7, 32'd5, 32'd0, "remu0");
    md_run(3'd4, MinVal, 32'hFFFF_FFFF, "div_ovf");
    md_run(3'd6, MinVal, 32'hFFFF_FFFF, "rem_ovf");
    md_run(3'd5, MinVal, 32'hFFFF_FFFF, "divu_big");
    for (int i = 0; i < 16; i++) begin
      md_run(3'($urandom_range(0, 7)), pick(), pick(), "md_rand");
    end

    // Flush on the 10th busy cycle: no completion, result held.
    @(negedge clk);
    alu_inst = 3'd2; inst = 5'b10000; op_a = 32'd3; op_b = 32'd5; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_eq("flush/stall", stall, 1'b0);
    check_eq("flush/done", md_done, 1'b0);
    check_eq("flush/result", md_result, last_res);
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (md_done) dn++;
    end
    check_eq("flush/no_done", dn, 0);
    md_run(3'd0, 32'd12, 32'd11, "after_flush");

    // Flush beats an M op presented in IDLE.
    @(negedge clk);
    alu_inst = 3'd2; inst = 5'b10100; op_a = 32'd9; op_b = 32'd2; valid = 1'b1; flush = 1'b1;
    #1;
    check_eq("idle_flush/stall", stall, 1'b0);
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (md_done || stall) dn++;
      @(negedge clk);
    end
    check_eq("idle_flush/no_start", dn, 0);

    // Reset in the middle of an op.
    alu_inst = 3'd2; inst = 5'b10000; op_a = 32'd6; op_b = 32'd7; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_eq("midrst/stall", stall, 1'b0);
    check_eq("midrst/done", md_done, 1'b0);
    check_eq("midrst/result", md_result, 32'h0);
    check_eq("midrst/ns_result", ns_md_result, 32'h0);
    rst = 1'b0;
    md_run(3'd4, 32'd100, 32'd7, "after_rst");

    check_eq("nom/never_busy", nom_busy, 0);
    check_eq("nom/result", nom_md_result, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
